// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO registers.
// One radix-2 step per cycle; busy stalls the front end for 33 cycles.
module mult_div_unit #(
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] m;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic [31:0] rs_sav;
  logic        is_div;
  logic        neg_p;
  logic        neg_a;
  logic        div0;

  logic        md_op;
  logic        sgn_op;
  logic        sa;
  logic        sb;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] sum;
  logic [32:0] shl;
  logic [33:0] diff;
  logic [63:0] prod;
  logic [63:0] prod_s;
  logic [31:0] quo;
  logic [31:0] rem;

  assign busy   = (state != IDLE);
  assign md_op  = start && !op[2];
  assign sgn_op = !op[0];
  assign sa     = sgn_op && rs_data[31];
  assign sb     = sgn_op && rt_data[31];
  assign mag_a  = sa ? -rs_data : rs_data;
  assign mag_b  = sb ? -rt_data : rt_data;

  // Multiply adds into the top half then shifts right; divide shifts left.
  assign sum    = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : 33'd0);
  assign shl    = {p_hi, p_lo[31]};
  assign diff   = {1'b0, shl} - {2'b00, m};

  assign prod   = {p_hi, p_lo};
  assign prod_s = neg_p ? -prod : prod;
  assign quo    = neg_p ? -p_lo : p_lo;
  assign rem    = neg_a ? -p_hi : p_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (md_op) state_nx = RUN;
      RUN:     if (cnt == 5'd31) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 5'd0;
      m      <= 32'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      rs_sav <= 32'd0;
      is_div <= 1'b0;
      neg_p  <= 1'b0;
      neg_a  <= 1'b0;
      div0   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        unique case (1'b1)
          !op[2]: begin
            cnt    <= 5'd0;
            is_div <= op[1];
            neg_p  <= sa ^ sb;
            neg_a  <= sa;
            div0   <= (rt_data == 32'd0);
            rs_sav <= rs_data;
            p_hi   <= 32'd0;
            m      <= op[1] ? mag_b : mag_a;
            p_lo   <= op[1] ? mag_a : mag_b;
          end
          op == 3'b100: hi <= rs_data;
          op == 3'b101: lo <= rs_data;
          default: ;
        endcase
      end else if (state == RUN) begin
        cnt <= cnt + 5'd1;
        if (!is_div) begin
          p_hi <= sum[32:1];
          p_lo <= {sum[0], p_lo[31:1]};
        end else if (!diff[33]) begin
          p_hi <= diff[31:0];
          p_lo <= {p_lo[30:0], 1'b1};
        end else begin
          p_hi <= shl[31:0];
          p_lo <= {p_lo[30:0], 1'b0};
        end
      end else if (state == FIX) begin
        done <= 1'b1;
        if (!is_div) begin
          hi <= prod_s[63:32];
          lo <= prod_s[31:0];
        end else if (div0) begin
          hi <= rs_sav;
          lo <= DIV0_LO;
        end else begin
          hi <= rem;
          lo <= quo;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: reset, multiply, divide,
// divide by zero and the busy interlock.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  mult_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    logic bad;
    reset = 1'b1;
    start = 1'b0;
    op = 3'b111;
    rs_data = 32'd0;
    rt_data = 32'd0;
    #3;
    checks++;
    if ({hi, lo, busy, done} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b want 0",
               hi, lo, busy, done);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    issue(MTHI, 32'h1111, 32'd0);
    issue(MTLO, 32'h2222, 32'd0);
    checks++;
    if (hi !== 32'h1111 || lo !== 32'h2222) begin
      errors++;
      $display("FAIL mthi_mtlo: got hi=%h lo=%h want 1111 2222", hi, lo);
    end
    issue(MULTU, 32'd5, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_run: got %b want 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({hi, lo, busy, done} !== 66'd0) begin
      errors++;
      $display("FAIL reset_async: got hi=%h lo=%h busy=%b done=%b want 0",
               hi, lo, busy, done);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got hi=%h lo=%h done=%b want 0", hi, lo, done);
    end
  endtask

  task automatic test_mult;
    logic [2:0]  ops [3] = '{MULTU, MULT, MULT};
    logic [31:0] va  [3] = '{32'hFFFF_FFFF, -32'sd3, 32'h8000_0000};
    logic [31:0] vb  [3] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000};
    logic [31:0] eh  [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000};
    logic [31:0] el  [3] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'h0};
    int n;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], va[i], vb[i]);
      wait_idle(n);
      checks++;
      if (n !== 33) begin
        errors++;
        $display("FAIL mult%0d_busy: got %0d cycles want 33", i, n);
      end
      checks++;
      if (done !== 1'b1 || hi !== eh[i] || lo !== el[i]) begin
        errors++;
        $display("FAIL mult%0d_res: got done=%b hi=%h lo=%h want 1 %h %h",
                 i, done, hi, lo, eh[i], el[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL mult%0d_done_drop: got %b want 0", i, done);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [5] = '{DIV, DIVU, DIV, DIVU, DIV};
    logic [31:0] va  [5] = '{-32'sd7, 32'd100, 32'h8000_0000, 32'd1234, -32'sd5};
    logic [31:0] vb  [5] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] eh  [5] = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1234, 32'hFFFF_FFFB};
    logic [31:0] el  [5] = '{32'hFFFF_FFFD, 32'd14, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int n;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], va[i], vb[i]);
      wait_idle(n);
      checks++;
      if (n !== 33) begin
        errors++;
        $display("FAIL div%0d_busy: got %0d cycles want 33", i, n);
      end
      checks++;
      if (done !== 1'b1 || hi !== eh[i] || lo !== el[i]) begin
        errors++;
        $display("FAIL div%0d_res: got done=%b hi=%h lo=%h want 1 %h %h",
                 i, done, hi, lo, eh[i], el[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL div%0d_done_drop: got %b want 0", i, done);
      end
    end
  endtask

  task automatic test_interlock;
    int n;
    issue(MULTU, 32'd2, 32'd3);
    issue(MTLO, 32'd99, 32'd0);
    issue(DIVU, 32'd50, 32'd5);
    wait_idle(n);
    checks++;
    if (n !== 31) begin
      errors++;
      $display("FAIL lock_busy: got %0d cycles want 31", n);
    end
    checks++;
    if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL lock_res: got done=%b hi=%h lo=%h want 1 0 6", done, hi, lo);
    end
    issue(MTLO, 32'd99, 32'd0);
    checks++;
    if (lo !== 32'd99 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_after: got lo=%h busy=%b done=%b want 63 0 0",
               lo, busy, done);
    end
    issue(3'b110, 32'hDEAD, 32'hBEEF);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd99 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nop: got hi=%h lo=%h busy=%b want 0 63 0", hi, lo, busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_interlock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
